tap_delay_line: RTL and testbench

Parametrised sample store for the adaptive-filter datapath: the successor to the fixed 16-bit single-word memory, generalised to WIDTH bits × DEPTH taps. Each accepted sample is pushed into a circular buffer with a one-cycle `done` acknowledge. Any tap can be read back by index (tap 0 = newest) through a registered read port. The filter and LMS update engines use it as the x[n−k] history.

---
 rtl/tap_delay_line.sv | 109 ++++++++++
 tb/tb_tap_delay_line.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tap_delay_line.sv
// tap_delay_line: WIDTH x DEPTH circular sample history with push acknowledge
// and a registered, index-addressed tap read port (tap 0 = newest sample).
module tap_delay_line #(
  parameter int WIDTH  = 16,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [WIDTH-1:0]  d,
  input  logic              enable,
  input  logic              clear,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  q,
  output logic              done,
  output logic [WIDTH-1:0]  rd_data,
  output logic              rd_valid,
  output logic [ADDR_W:0]   count,
  output logic              full
);

  localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W:0]   DEPTH_C = (ADDR_W + 1)'(DEPTH);

  // Storage is sized to the full address space so every index is legal;
  // only entries 0..DEPTH-1 are ever written.
  logic [WIDTH-1:0] mem_q [2**ADDR_W];

  logic [ADDR_W-1:0] wptr_q, wptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic [WIDTH-1:0]  q_q, q_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  rd_data_q, rd_data_d;
  logic              rd_valid_q, rd_valid_d;
  logic              full_q, full_d;

  logic              push;
  logic              hit;
  logic [ADDR_W-1:0] tap_idx;

  // Clear wins over enable, so a push only happens when clear is low.
  assign push = enable & ~clear;

  // Tap k lives at (wptr-1-k) mod DEPTH; the wrap is resolved with a compare
  // instead of a power-of-two mask. Only meaningful when rd_addr < count.
  always_comb begin
    hit     = ({1'b0, rd_addr} < count_q);
    tap_idx = (wptr_q > rd_addr) ? (wptr_q - ADDR_W'(1) - rd_addr)
                                 : (wptr_q + LAST - rd_addr);
  end

  // Next-state: reads see the pre-push pointer/count, clear overrides all.
  always_comb begin
    wptr_d     = wptr_q;
    count_d    = count_q;
    q_d        = q_q;
    done_d     = push;
    rd_valid_d = rd_en;
    rd_data_d  = rd_data_q;
    if (rd_en) rd_data_d = hit ? mem_q[tap_idx] : '0;
    if (push) begin
      wptr_d  = (wptr_q == LAST) ? '0 : wptr_q + ADDR_W'(1);
      count_d = (count_q == DEPTH_C) ? count_q : count_q + (ADDR_W + 1)'(1);
      q_d     = d;
    end
    if (clear) begin
      wptr_d    = '0;
      count_d   = '0;
      q_d       = '0;
      rd_data_d = '0;
    end
    full_d = (count_d == DEPTH_C);
  end

  // Control and output registers, asynchronously cleared.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wptr_q     <= '0;
      count_q    <= '0;
      q_q        <= '0;
      done_q     <= 1'b0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      full_q     <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      count_q    <= count_d;
      q_q        <= q_d;
      done_q     <= done_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      full_q     <= full_d;
    end
  end

  // Sample array; contents are not reset, validity is tracked by count.
  always_ff @(posedge clock) begin
    if (push) mem_q[wptr_q] <= d;
  end

  assign q        = q_q;
  assign done     = done_q;
  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign count    = count_q;
  assign full     = full_q;

endmodule

// File: tb/tb_tap_delay_line.sv
// Bench for tap_delay_line: a DEPTH=4 and a DEPTH=5 instance share stimulus;
// each is compared every cycle to a shift-history model, plus a vector table
// and directed corner sequences.
module tb_tap_delay_line;
  localparam int W  = 16;
  localparam int AW = 3;

  logic          clock = 1'b0;
  logic          reset;
  logic [W-1:0]  d;
  logic          enable, clear, rd_en;
  logic [AW-1:0] rd_addr;

  logic [W-1:0]  q4, rd4, q5, rd5;
  logic          done4, done5, rv4, rv5, full4, full5;
  logic [AW:0]   cnt4, cnt5;

  always #5 clock = ~clock;

  tap_delay_line #(.WIDTH(W), .DEPTH(4), .ADDR_W(AW)) u_d4 (
    .clock(clock), .reset(reset), .d(d), .enable(enable), .clear(clear),
    .rd_en(rd_en), .rd_addr(rd_addr), .q(q4), .done(done4), .rd_data(rd4),
    .rd_valid(rv4), .count(cnt4), .full(full4));

  tap_delay_line #(.WIDTH(W), .DEPTH(5), .ADDR_W(AW)) u_d5 (
    .clock(clock), .reset(reset), .d(d), .enable(enable), .clear(clear),
    .rd_en(rd_en), .rd_addr(rd_addr), .q(q5), .done(done5), .rd_data(rd5),
    .rd_valid(rv5), .count(cnt5), .full(full5));

  int checks = 0;
  int errors = 0;

  // Reference: history as a newest-first list, plus the registered outputs.
  logic [W-1:0] mh [2][8];
  int           mcnt [2];
  logic [W-1:0] mq [2];
  logic [W-1:0] mrd [2];
  logic         mdone [2];
  logic         mrv [2];

  function automatic int dep(int m);
    return (m == 0) ? 4 : 5;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      mcnt[m] = 0; mq[m] = '0; mrd[m] = '0; mdone[m] = 1'b0; mrv[m] = 1'b0;
    end
  endtask

  task automatic model_step();
    for (int m = 0; m < 2; m++) begin
      if (clear) begin
        mcnt[m] = 0; mq[m] = '0; mdone[m] = 1'b0; mrd[m] = '0; mrv[m] = rd_en;
      end else begin
        mrv[m] = rd_en;
        if (rd_en) mrd[m] = (int'(rd_addr) < mcnt[m]) ? mh[m][rd_addr] : '0;
        mdone[m] = enable;
        if (enable) begin
          for (int i = 7; i > 0; i--) mh[m][i] = mh[m][i-1];
          mh[m][0] = d;
          if (mcnt[m] < dep(m)) mcnt[m]++;
          mq[m] = d;
        end
      end
    end
  endtask

  task automatic check_all();
    chk("m4_q", q4, mq[0]);        chk("m5_q", q5, mq[1]);
    chk("m4_done", done4, mdone[0]); chk("m5_done", done5, mdone[1]);
    chk("m4_rd", rd4, mrd[0]);     chk("m5_rd", rd5, mrd[1]);
    chk("m4_rv", rv4, mrv[0]);     chk("m5_rv", rv5, mrv[1]);
    chk("m4_cnt", cnt4, mcnt[0]);  chk("m5_cnt", cnt5, mcnt[1]);
    chk("m4_full", full4, mcnt[0] == 4); chk("m5_full", full5, mcnt[1] == 5);
  endtask

  task automatic drive(logic en, logic clr, logic [W-1:0] dd, logic re, logic [AW-1:0] ra);
    enable = en; clear = clr; d = dd; rd_en = re; rd_addr = ra;
  endtask

  // One clock: model follows the edge, outputs sampled 1 time unit later.
  task automatic cyc();
    @(posedge clock);
    model_step();
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
  endtask

  typedef struct {
    logic          en, clr, re;
    logic [W-1:0]  d;
    logic [AW-1:0] a;
    logic [W-1:0]  eq, erd;
    logic          edone, erv, efull;
    logic [AW:0]   ecnt;
  } vec_t;

  vec_t tv [12];

  function automatic vec_t mk(logic en, logic clr, logic [W-1:0] dd, logic re,
                              logic [AW-1:0] a, logic [W-1:0] eq, logic edone,
                              logic [W-1:0] erd, logic erv, logic [AW:0] ecnt,
                              logic efull);
    vec_t v;
    v.en = en; v.clr = clr; v.d = dd; v.re = re; v.a = a;
    v.eq = eq; v.edone = edone; v.erd = erd; v.erv = erv; v.ecnt = ecnt; v.efull = efull;
    return v;
  endfunction

  initial begin
    // Expected outputs of the DEPTH=4 instance after each edge.
    tv[0]  = mk(1, 0, 1, 1, 0,  1, 1, 0, 1, 1, 0);
    tv[1]  = mk(1, 0, 2, 1, 0,  2, 1, 1, 1, 2, 0);
    tv[2]  = mk(1, 0, 3, 1, 1,  3, 1, 1, 1, 3, 0);
    tv[3]  = mk(1, 0, 4, 0, 0,  4, 1, 1, 0, 4, 1);
    tv[4]  = mk(0, 0, 0, 1, 0,  4, 0, 4, 1, 4, 1);
    tv[5]  = mk(0, 0, 0, 1, 3,  4, 0, 1, 1, 4, 1);
    tv[6]  = mk(1, 0, 5, 1, 2,  5, 1, 2, 1, 4, 1);
    tv[7]  = mk(0, 0, 0, 1, 3,  5, 0, 2, 1, 4, 1);
    tv[8]  = mk(0, 0, 0, 1, 0,  5, 0, 5, 1, 4, 1);
    tv[9]  = mk(0, 0, 0, 1, 4,  5, 0, 0, 1, 4, 1);
    tv[10] = mk(1, 1, 9, 1, 0,  0, 0, 0, 1, 0, 0);
    tv[11] = mk(0, 0, 0, 1, 0,  0, 0, 0, 1, 0, 0);

    drive(0, 0, '0, 0, '0);
    reset = 1'b0;
    model_reset();
    #1;
    chk("rst_q", q4, 0); chk("rst_cnt", cnt4, 0); chk("rst_full", full4, 0);
    @(posedge clock);
    #1;
    reset = 1'b1;

    // Fill, wrap, out-of-range read and clear-versus-push on DEPTH=4.
    for (int i = 0; i < 12; i++) begin
      drive(tv[i].en, tv[i].clr, tv[i].d, tv[i].re, tv[i].a);
      cyc();
      chk($sformatf("tbl%0d_q", i), q4, tv[i].eq);
      chk($sformatf("tbl%0d_done", i), done4, tv[i].edone);
      chk($sformatf("tbl%0d_rd", i), rd4, tv[i].erd);
      chk($sformatf("tbl%0d_rv", i), rv4, tv[i].erv);
      chk($sformatf("tbl%0d_cnt", i), cnt4, tv[i].ecnt);
      chk($sformatf("tbl%0d_full", i), full4, tv[i].efull);
    end

    // Single push, done for exactly one cycle, then tap 0 / tap 1 reads.
    do_reset();
    drive(1, 0, 16'hABCD, 0, 0); cyc();
    chk("sp_q", q4, 16'hABCD); chk("sp_done", done4, 1);
    chk("sp_cnt", cnt4, 1); chk("sp_full", full4, 0);
    drive(0, 0, 0, 1, 0); cyc();
    chk("sp_done_drop", done4, 0); chk("sp_tap0", rd4, 16'hABCD);
    drive(0, 0, 0, 1, 1); cyc();
    chk("sp_tap1", rd4, 0); chk("sp_tap1_v", rv4, 1);

    // Read during push returns the pre-push history.
    do_reset();
    drive(1, 0, 1, 0, 0); cyc();
    drive(1, 0, 2, 0, 0); cyc();
    drive(1, 0, 7, 1, 0); cyc();
    chk("rw_pre", rd4, 2);
    drive(0, 0, 0, 1, 0); cyc();
    chk("rw_post", rd4, 7);

    // Asynchronous reset mid-stream with count=3.
    do_reset();
    for (int i = 1; i <= 3; i++) begin drive(1, 0, W'(i), 1, 0); cyc(); end
    chk("ar_cnt3", cnt4, 3);
    drive(0, 0, 0, 0, 0);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_q", q4, 0); chk("ar_done", done4, 0); chk("ar_rd", rd4, 0);
    chk("ar_rv", rv4, 0); chk("ar_cnt", cnt4, 0); chk("ar_full", full4, 0);
    model_reset();
    @(posedge clock);
    #1;
    reset = 1'b1;
    drive(0, 0, 0, 1, 0); cyc();
    chk("ar_read_rd", rd4, 0); chk("ar_read_v", rv4, 1);

    // Non-power-of-two depth: DEPTH=5 instance after 7 pushes.
    do_reset();
    for (int i = 1; i <= 7; i++) begin drive(1, 0, W'(i), 0, 0); cyc(); end
    chk("np_cnt", cnt5, 5); chk("np_full", full5, 1);
    for (int k = 0; k < 5; k++) begin
      drive(0, 0, 0, 1, AW'(k)); cyc();
      chk($sformatf("np_tap%0d", k), rd5, 7 - k);
    end
    drive(0, 0, 0, 1, 6); cyc();
    chk("np_oob", rd5, 0); chk("np_oob_v", rv5, 1);

    // Random traffic against the reference model.
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive(($urandom % 4) != 0, ($urandom % 20) == 0, W'($urandom),
            ($urandom % 3) != 0, AW'($urandom));
      cyc();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
